// File: rtl/csr_master_bridge.sv
// Wishbone classic (16-bit) slave to CSR master bridge. Each WB cycle becomes
// one CSR write pulse or one fixed-latency CSR read, answered by a single-cycle ack.
module csr_master_bridge #(
  parameter int RD_LAT  = 2,
  parameter int GAP_CYC = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [16:0] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [16:0] csr_adr_o,
  output logic [1:0]  csr_sel_o,
  output logic        csr_we_o,
  output logic [15:0] csr_dat_o,
  input  logic [15:0] csr_dat_i
);

  localparam int CW = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    gap_q, gap_d;
  logic          abort_q, abort_d;
  logic          done_q, done_d;
  logic [16:0]   csr_adr_q, csr_adr_d;
  logic [1:0]    csr_sel_q, csr_sel_d;
  logic [15:0]   csr_dat_q, csr_dat_d;
  logic          csr_we_q, csr_we_d;
  logic          wb_ack_q, wb_ack_d;
  logic [15:0]   wb_dat_q, wb_dat_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    abort_d   = abort_q;
    done_d    = done_q;
    csr_adr_d = csr_adr_q;
    csr_sel_d = csr_sel_q;
    csr_dat_d = csr_dat_q;
    csr_we_d  = 1'b0;
    wb_ack_d  = 1'b0;
    wb_dat_d  = wb_dat_q;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          csr_adr_d = wb_adr_i;
          csr_sel_d = wb_sel_i;
          csr_dat_d = wb_dat_i;
          abort_d   = 1'b0;
          if (wb_we_i) begin
            csr_we_d = 1'b1;
            done_d   = 1'b0;
            state_d  = ACK;
          end else begin
            // Data is sampled on the edge this reaches 1: RD_LAT+1 edges
            // after the address register edge.
            cnt_d   = CW'(RD_LAT + 1);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (!wb_cyc_i) abort_d = 1'b1;
        if (cnt_q == CW'(1)) begin
          // The read always counts out; only the WB side is suppressed on abort.
          if (wb_cyc_i && !abort_q) begin
            wb_ack_d = 1'b1;
            wb_dat_d = csr_dat_i;
          end
          done_d  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!done_q) begin
          // Write: ack follows the single CSR strobe cycle.
          wb_ack_d = wb_cyc_i;
          done_d   = 1'b1;
        end else begin
          gap_d   = 3'(GAP_CYC);
          state_d = (GAP_CYC > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q <= 3'd1) state_d = IDLE;
        else               gap_d   = gap_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      csr_adr_q <= '0;
      csr_sel_q <= '0;
      csr_dat_q <= '0;
      csr_we_q  <= 1'b0;
      wb_ack_q  <= 1'b0;
      wb_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
      csr_adr_q <= csr_adr_d;
      csr_sel_q <= csr_sel_d;
      csr_dat_q <= csr_dat_d;
      csr_we_q  <= csr_we_d;
      wb_ack_q  <= wb_ack_d;
      wb_dat_q  <= wb_dat_d;
    end
  end

  assign csr_adr_o = csr_adr_q;
  assign csr_sel_o = csr_sel_q;
  assign csr_dat_o = csr_dat_q;
  assign csr_we_o  = csr_we_q;
  assign wb_ack_o  = wb_ack_q;
  assign wb_dat_o  = wb_dat_q;

endmodule

// File: tb/tb_csr_master_bridge.sv
// Bench for csr_master_bridge: registered-address CSR slave (2-edge read
// latency) plus a transaction-level reference memory.
module tb_csr_master_bridge;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [16:0] wb_adr_i = '0;
  logic [1:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic [16:0] csr_adr_o;
  logic [1:0]  csr_sel_o;
  logic        csr_we_o;
  logic [15:0] csr_dat_o;
  logic [15:0] csr_dat_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ref_mem [0:255];
  logic [15:0] smem    [0:255];
  logic [16:0] s_adr_r;
  logic [15:0] last_rd;

  csr_master_bridge #(.RD_LAT(2), .GAP_CYC(1)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .csr_adr_o(csr_adr_o),
    .csr_sel_o(csr_sel_o), .csr_we_o(csr_we_o), .csr_dat_o(csr_dat_o),
    .csr_dat_i(csr_dat_i)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave: address registered on one edge, data registered on the next.
  initial begin
    for (int i = 0; i < 256; i++) smem[i] = 16'h0;
    s_adr_r   = '0;
    csr_dat_i = '0;
  end

  always @(posedge sys_clk) begin
    s_adr_r   <= csr_adr_o;
    csr_dat_i <= smem[s_adr_r[7:0]];
    if (csr_we_o) begin
      if (csr_sel_o[0]) smem[csr_adr_o[7:0]][7:0]  <= csr_dat_o[7:0];
      if (csr_sel_o[1]) smem[csr_adr_o[7:0]][15:8] <= csr_dat_o[15:8];
    end
  end

  function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                        input logic [1:0] sel);
    logic [15:0] mask;
    mask = {{8{sel[1]}}, {8{sel[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Issues one transfer after a few idle edges; edge 0 is the first edge
  // that sees the request.
  task automatic wb_xfer(input logic we, input logic [16:0] adr, input logic [1:0] sel,
                         input logic [15:0] dat, input logic rel,
                         output int ack_e, output int we_e, output int we_n,
                         output logic [15:0] rdat, output logic [16:0] we_adr,
                         output logic [15:0] we_dat);
    ack_e = -1; we_e = -1; we_n = 0; rdat = 'x; we_adr = 'x; we_dat = 'x;
    repeat (4) @(posedge sys_clk);
    #1;
    if (rel) sys_rst_n = 1'b1;
    wb_we_i = we; wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int e = 0; e < 16; e++) begin
      @(posedge sys_clk);
      #1;
      if (csr_we_o) begin
        if (we_e < 0) begin we_e = e; we_adr = csr_adr_o; we_dat = csr_dat_o; end
        we_n++;
      end
      if (wb_ack_o) begin ack_e = e; rdat = wb_dat_o; break; end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic test_reset;
    #3 sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wb_ack_o, wb_dat_o, csr_adr_o, csr_sel_o, csr_we_o, csr_dat_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ack=%b dat=%h adr=%h sel=%b we=%b cdat=%h, want all 0",
               wb_ack_o, wb_dat_o, csr_adr_o, csr_sel_o, csr_we_o, csr_dat_o);
    end
    repeat (2) @(posedge sys_clk);
    #1;
    n_cmp++;
    if ({wb_ack_o, csr_we_o} !== 2'b00) begin
      n_err++; $display("FAIL reset_hold: got ack=%b we=%b want 0 0", wb_ack_o, csr_we_o);
    end
    sys_rst_n = 1'b1;
    last_rd = 16'h0;
  endtask

  task automatic test_write_read;
    int a, w, n; logic [15:0] rd, wd; logic [16:0] wa;
    wb_xfer(1'b1, 17'h00010, 2'b11, 16'h1234, 1'b0, a, w, n, rd, wa, wd);
    ref_mem[8'h10] = merge(ref_mem[8'h10], 16'h1234, 2'b11);
    n_cmp++; if (w !== 0 || n !== 1) begin n_err++; $display("FAIL wr_we_pulse: edge %0d width %0d want 0 1", w, n); end
    n_cmp++; if (wa !== 17'h00010 || wd !== 16'h1234) begin n_err++; $display("FAIL wr_csr_bus: adr %h dat %h want 00010 1234", wa, wd); end
    n_cmp++; if (a !== 1) begin n_err++; $display("FAIL wr_ack_edge: got %0d want 1", a); end
    n_cmp++; if (smem[8'h10] !== 16'h1234) begin n_err++; $display("FAIL wr_slave_mem: got %h want 1234", smem[8'h10]); end
    n_cmp++; if (wb_dat_o !== last_rd) begin n_err++; $display("FAIL wr_keeps_rdata: got %h want %h", wb_dat_o, last_rd); end
    wb_xfer(1'b0, 17'h00010, 2'b11, 16'h0, 1'b0, a, w, n, rd, wa, wd);
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL rd_no_we: got %0d strobes want 0", n); end
    n_cmp++; if (a !== 3) begin n_err++; $display("FAIL rd_ack_edge: got %0d want 3", a); end
    n_cmp++; if (rd !== 16'h1234) begin n_err++; $display("FAIL rd_data: got %h want 1234", rd); end
    last_rd = rd;
  endtask

  task automatic test_byte_sel;
    int a, w, n; logic [15:0] rd, wd; logic [16:0] wa;
    wb_xfer(1'b1, 17'h00020, 2'b11, 16'h1234, 1'b0, a, w, n, rd, wa, wd);
    wb_xfer(1'b1, 17'h00020, 2'b01, 16'hABCD, 1'b0, a, w, n, rd, wa, wd);
    wb_xfer(1'b0, 17'h00020, 2'b11, 16'h0,    1'b0, a, w, n, rd, wa, wd);
    n_cmp++; if (rd !== 16'h12CD) begin n_err++; $display("FAIL byte_sel01: got %h want 12cd", rd); end
    wb_xfer(1'b1, 17'h00020, 2'b10, 16'h5600, 1'b0, a, w, n, rd, wa, wd);
    wb_xfer(1'b0, 17'h00020, 2'b11, 16'h0,    1'b0, a, w, n, rd, wa, wd);
    n_cmp++; if (rd !== 16'h56CD) begin n_err++; $display("FAIL byte_sel10: got %h want 56cd", rd); end
    ref_mem[8'h20] = 16'h56CD;
    last_rd = rd;
  endtask

  task automatic test_random;
    int a, w, n; logic [15:0] rd, wd, dat; logic [16:0] wa, adr; logic [1:0] sel; logic we;
    for (int t = 0; t < 40; t++) begin
      adr = {9'($urandom_range(0, 511)), 8'($urandom_range(0, 15) * 3)};
      we  = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(1, 3));
      dat = 16'($urandom);
      wb_xfer(we, adr, sel, dat, 1'b0, a, w, n, rd, wa, wd);
      if (we) begin
        ref_mem[adr[7:0]] = merge(ref_mem[adr[7:0]], dat, sel);
        n_cmp++;
        if (a !== 1 || n !== 1 || wa !== adr || wd !== dat) begin
          n_err++;
          $display("FAIL rand_wr[%0d]: ack %0d strobes %0d adr %h dat %h want 1 1 %h %h", t, a, n, wa, wd, adr, dat);
        end
        n_cmp++; if (wb_dat_o !== last_rd) begin n_err++; $display("FAIL rand_wr_rdata[%0d]: got %h want %h", t, wb_dat_o, last_rd); end
      end else begin
        n_cmp++;
        if (a !== 3 || n !== 0 || rd !== ref_mem[adr[7:0]]) begin
          n_err++;
          $display("FAIL rand_rd[%0d]: ack %0d strobes %0d data %h want 3 0 %h", t, a, n, rd, ref_mem[adr[7:0]]);
        end
        last_rd = ref_mem[adr[7:0]];
      end
    end
  endtask

  // Strobe held across two writes: the second request waits out ACK and GAP.
  task automatic test_back_to_back;
    int we_e[$], ack_e[$];
    repeat (4) @(posedge sys_clk);
    #1;
    wb_we_i = 1'b1; wb_adr_i = 17'h00040; wb_sel_i = 2'b11; wb_dat_i = 16'h1111;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(posedge sys_clk);
      #1;
      if (csr_we_o) we_e.push_back(e);
      if (wb_ack_o) begin
        ack_e.push_back(e);
        if (ack_e.size() == 1) begin wb_adr_i = 17'h00041; wb_dat_i = 16'h2222; end
        else begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    ref_mem[8'h40] = 16'h1111; ref_mem[8'h41] = 16'h2222;
    n_cmp++;
    if (ack_e.size() !== 2) begin n_err++; $display("FAIL b2b_ack_count: got %0d want 2", ack_e.size()); end
    else begin
      n_cmp++; if (ack_e[0] !== 1 || ack_e[1] !== 5) begin n_err++; $display("FAIL b2b_ack_edges: got %0d %0d want 1 5", ack_e[0], ack_e[1]); end
    end
    n_cmp++;
    if (we_e.size() !== 2) begin n_err++; $display("FAIL b2b_we_count: got %0d want 2", we_e.size()); end
    else begin
      n_cmp++; if (we_e[0] !== 0 || we_e[1] !== 4) begin n_err++; $display("FAIL b2b_we_edges: got %0d %0d want 0 4", we_e[0], we_e[1]); end
    end
    n_cmp++;
    if (smem[8'h40] !== 16'h1111 || smem[8'h41] !== 16'h2222) begin
      n_err++; $display("FAIL b2b_slave_mem: got %h %h want 1111 2222", smem[8'h40], smem[8'h41]);
    end
  endtask

  task automatic test_abort;
    int a, w, n, acks; logic [15:0] rd, wd; logic [16:0] wa;
    wb_xfer(1'b1, 17'h00050, 2'b11, 16'hBEEF, 1'b0, a, w, n, rd, wa, wd);
    ref_mem[8'h50] = 16'hBEEF;
    repeat (4) @(posedge sys_clk);
    #1;
    wb_we_i = 1'b0; wb_adr_i = 17'h00050; wb_sel_i = 2'b11; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge sys_clk);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    acks = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge sys_clk);
      #1;
      if (wb_ack_o) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
    n_cmp++; if (wb_dat_o !== last_rd) begin n_err++; $display("FAIL abort_rdata: got %h want %h", wb_dat_o, last_rd); end
    wb_xfer(1'b0, 17'h00010, 2'b11, 16'h0, 1'b0, a, w, n, rd, wa, wd);
    n_cmp++;
    if (a !== 3 || rd !== ref_mem[8'h10]) begin
      n_err++; $display("FAIL abort_next_rd: ack %0d data %h want 3 %h", a, rd, ref_mem[8'h10]);
    end
    last_rd = rd;
  endtask

  task automatic test_reset_mid;
    int a, w, n; logic [15:0] rd, wd; logic [16:0] wa;
    repeat (4) @(posedge sys_clk);
    #1;
    wb_we_i = 1'b0; wb_adr_i = 17'h00040; wb_sel_i = 2'b11; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wb_ack_o, wb_dat_o, csr_adr_o, csr_sel_o, csr_we_o, csr_dat_o} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs: got ack=%b dat=%h adr=%h sel=%b we=%b cdat=%h, want all 0",
               wb_ack_o, wb_dat_o, csr_adr_o, csr_sel_o, csr_we_o, csr_dat_o);
    end
    // Request stays asserted through reset and is released together with it.
    wb_xfer(1'b0, 17'h00041, 2'b11, 16'h0, 1'b1, a, w, n, rd, wa, wd);
    n_cmp++;
    if (a !== 3 || rd !== ref_mem[8'h41]) begin
      n_err++; $display("FAIL midrst_next_rd: ack %0d data %h want 3 %h", a, rd, ref_mem[8'h41]);
    end
    last_rd = rd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    last_rd = 16'h0;
    test_reset;
    test_write_read;
    test_byte_sel;
    test_random;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
